// File: rtl/msg_slot_sequencer.sv
// msg_slot_sequencer
// Front end of the 16-slot message buffer. Turns a valid/ready character
// stream into one write strobe (WE), a 4-bit slot index (SEL) and a shared
// data bus (WDATA) that feed the 1-to-16 slot demultiplexer.
//
// Build option: define SLOT_CLEAR_EN to blank-fill all 16 slots with FILL
// before each message is loaded. Without it, START goes straight to loading
// and slots that are not written keep their previous contents.
module msg_slot_sequencer #(
    parameter int                 DATA_W = 8,
    parameter logic [DATA_W-1:0]  FILL   = 8'h20
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_LAST,
    output logic              IN_READY,
    output logic              WE,
    output logic [3:0]        SEL,
    output logic [DATA_W-1:0] WDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [4:0]        COUNT,
    output logic              OVF
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_LOAD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    // ptr_q is the next slot to write; bit 4 set means all 16 slots are used.
    logic [4:0]        ptr_q, ptr_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [4:0]        count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              accept_s;
    logic              restart_s;

`ifndef SLOT_CLEAR_EN
    // The blank character only matters when the clear sweep is built in.
    logic              unused_fill_s;
    assign unused_fill_s = ^FILL;
`endif

    // Ready only while loading; a simultaneous START (restart) or RST wins.
    assign IN_READY  = (state_q == S_LOAD) & ~START & ~RST;
    assign accept_s  = IN_VALID & IN_READY;
    // START is honoured in IDLE and LOAD only; CLEAR and DONE ignore it.
    assign restart_s = START & ((state_q == S_IDLE) | (state_q == S_LOAD));

    // Next-state and registered-output logic for the message sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (restart_s) begin
            count_d = 5'd0;
            ovf_d   = 1'b0;
`ifdef SLOT_CLEAR_EN
            // First blank write is issued on the same edge that enters CLEAR.
            state_d = S_CLEAR;
            we_d    = 1'b1;
            sel_d   = 4'd0;
            wdata_d = FILL;
            ptr_d   = 5'd1;
`else
            state_d = S_LOAD;
            ptr_d   = 5'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
`ifdef SLOT_CLEAR_EN
                S_CLEAR: begin
                    if (ptr_q[4]) begin
                        state_d = S_LOAD;
                        ptr_d   = 5'd0;
                    end else begin
                        we_d    = 1'b1;
                        sel_d   = ptr_q[3:0];
                        wdata_d = FILL;
                        ptr_d   = ptr_q + 5'd1;
                    end
                end
`endif
                S_LOAD: begin
                    if (accept_s) begin
                        if (!ptr_q[4]) begin
                            we_d    = 1'b1;
                            sel_d   = ptr_q[3:0];
                            wdata_d = IN_DATA;
                            ptr_d   = ptr_q + 5'd1;
                            if (count_q != 5'd16) begin
                                count_d = count_q + 5'd1;
                            end else begin
                                count_d = count_q;
                            end
                        end else begin
                            // Buffer full: the beat is consumed but never wraps to slot 0.
                            ovf_d = 1'b1;
                        end
                        if (IN_LAST) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_CLEAR) | (state_d == S_LOAD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ptr_q   <= 5'd0;
            we_q    <= 1'b0;
            sel_q   <= 4'd0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= 5'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign WE    = we_q;
    assign SEL   = sel_q;
    assign WDATA = wdata_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign COUNT = count_q;
    assign OVF   = ovf_q;

endmodule

// File: tb/tb_msg_slot_sequencer.sv
// Scoreboard bench for msg_slot_sequencer. Stimulus pushes the expected
// write/done events (with the cycle they must appear in); a monitor pops
// and compares whenever the DUT shows WE or DONE.
module tb_msg_slot_sequencer;

    localparam int         DATA_W = 8;
    localparam logic [7:0] FILL   = 8'h20;
`ifdef SLOT_CLEAR_EN
    localparam int         CLR    = 16;
`else
    localparam int         CLR    = 0;
`endif

    logic              CLK = 1'b0;
    logic              RST;
    logic              START;
    logic              IN_VALID;
    logic [DATA_W-1:0] IN_DATA;
    logic              IN_LAST;
    logic              IN_READY;
    logic              WE;
    logic [3:0]        SEL;
    logic [DATA_W-1:0] WDATA;
    logic              BUSY;
    logic              DONE;
    logic [4:0]        COUNT;
    logic              OVF;

    typedef struct {
        bit         we;
        logic [3:0] sel;
        logic [7:0] data;
        bit         done;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    msg_slot_sequencer #(.DATA_W(DATA_W), .FILL(FILL)) dut (
        .CLK(CLK), .RST(RST), .START(START), .IN_VALID(IN_VALID),
        .IN_DATA(IN_DATA), .IN_LAST(IN_LAST), .IN_READY(IN_READY),
        .WE(WE), .SEL(SEL), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE),
        .COUNT(COUNT), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every WE or DONE cycle must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (WE === 1'b1 || DONE === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got WE=%b SEL=%0d WDATA=0x%0h DONE=%b, want no event (cycle %0d)",
                         WE, SEL, WDATA, DONE, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("mon_we",    {31'd0, WE},   {31'd0, mon_e.we});
                chk("mon_done",  {31'd0, DONE}, {31'd0, mon_e.done});
                chk("mon_cycle", cyc,           mon_e.cyc);
                if (mon_e.we) begin
                    chk("mon_sel",   {28'd0, SEL},  {28'd0, mon_e.sel});
                    chk("mon_wdata", {24'd0, WDATA}, {24'd0, mon_e.data});
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input bit we, input logic [3:0] sel, input logic [7:0] d,
                            input bit done, input int c);
        exp_t e;
        e.we = we; e.sel = sel; e.data = d; e.done = done; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic start_msg(input bit with_beat, input bit wait_clear);
        START    = 1'b1;
        IN_VALID = with_beat;
        IN_DATA  = 8'h7A;
        IN_LAST  = 1'b0;
        @(negedge CLK);
        chk("in_ready_on_start", {31'd0, IN_READY}, 32'd0);
        for (int i = 0; i < CLR; i++) push_exp(1'b1, i[3:0], FILL, 1'b0, cyc + 1 + i);
        tick();
        START    = 1'b0;
        IN_VALID = 1'b0;
        if (wait_clear) repeat (CLR) tick();
    endtask

    task automatic send(input logic [7:0] d, input bit last, input bit wr, input logic [3:0] sel);
        IN_VALID = 1'b1;
        IN_DATA  = d;
        IN_LAST  = last;
        @(negedge CLK);
        chk("in_ready", {31'd0, IN_READY}, 32'd1);
        chk("busy",     {31'd0, BUSY},     32'd1);
        if (wr || last) push_exp(wr, sel, d, last, cyc + 1);
        tick();
    endtask

    task automatic gap();
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
        tick();
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40; k++) begin
            if (q.size() == 0) break;
            tick();
        end
        chk(name, q.size(), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge CLK);
        chk({tag, "_we"},       {31'd0, WE},       32'd0);
        chk({tag, "_sel"},      {28'd0, SEL},      32'd0);
        chk({tag, "_wdata"},    {24'd0, WDATA},    32'd0);
        chk({tag, "_count"},    {27'd0, COUNT},    32'd0);
        chk({tag, "_ovf"},      {31'd0, OVF},      32'd0);
        chk({tag, "_done"},     {31'd0, DONE},     32'd0);
        chk({tag, "_busy"},     {31'd0, BUSY},     32'd0);
        chk({tag, "_in_ready"}, {31'd0, IN_READY}, 32'd0);
        tick();
    endtask

    task automatic check_end(input string tag, input logic [4:0] cnt, input bit ovf);
        @(negedge CLK);
        chk({tag, "_count"},    {27'd0, COUNT},    {27'd0, cnt});
        chk({tag, "_ovf"},      {31'd0, OVF},      {31'd0, ovf});
        chk({tag, "_busy"},     {31'd0, BUSY},     32'd0);
        chk({tag, "_in_ready"}, {31'd0, IN_READY}, 32'd0);
        tick();
    endtask

    // Watchdog: never let the run hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; START = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'h00; IN_LAST = 1'b0;
        repeat (2) tick();
        check_reset_state("rst");
        RST = 1'b0;
        check_reset_state("idle");

        // Reset in the middle of a message (during the sweep at SEL=5 when built in).
        start_msg(1'b0, 1'b0);
`ifdef SLOT_CLEAR_EN
        repeat (5) tick();
`else
        send(8'h55, 1'b0, 1'b1, 4'd0);
`endif
        RST      = 1'b1;
        IN_VALID = 1'b1;
        IN_DATA  = 8'h66;
        @(negedge CLK);
        chk("busy_pre_rst",     {31'd0, BUSY},     32'd1);
        chk("in_ready_pre_rst", {31'd0, IN_READY}, 32'd0);
        tick();
        q.delete();
        check_reset_state("midrst1");
        check_reset_state("midrst2");
        RST      = 1'b0;
        IN_VALID = 1'b0;
        check_reset_state("postrst");

        // Short message "HI", back-to-back.
        start_msg(1'b0, 1'b1);
        send(8'h48, 1'b0, 1'b1, 4'd0);
        send(8'h49, 1'b1, 1'b1, 4'd1);
        gap();
        drain("drain_hi");
        check_end("hi", 5'd2, 1'b0);

        // Full buffer plus two dropped beats, LAST on the 18th.
        start_msg(1'b0, 1'b1);
        for (int i = 0; i < 18; i++) begin
            logic [7:0] d;
            d = 8'h41 + i[7:0];
            send(d, (i == 17), (i < 16), i[3:0]);
        end
        gap();
        drain("drain_ovf");
        check_end("ovf", 5'd16, 1'b1);

        // Gaps between beats.
        start_msg(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            d = 8'h61 + i[7:0];
            send(d, (i == 3), 1'b1, i[3:0]);
            gap();
        end
        drain("drain_gap");
        check_end("gap", 5'd4, 1'b0);

        // Restart collision: START with a valid beat after 3 writes.
        start_msg(1'b0, 1'b1);
        send(8'h31, 1'b0, 1'b1, 4'd0);
        send(8'h32, 1'b0, 1'b1, 4'd1);
        send(8'h33, 1'b0, 1'b1, 4'd2);
        start_msg(1'b1, 1'b1);
        @(negedge CLK);
        chk("restart_count", {27'd0, COUNT}, 32'd0);
        chk("restart_busy",  {31'd0, BUSY},  32'd1);
        tick();
        send(8'h39, 1'b1, 1'b1, 4'd0);
        gap();
        drain("drain_restart");
        check_end("restart", 5'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
